// File: rtl/oufbuf_ctrl.sv
// CNN output frame buffer controller: fills a frame buffer and scans it out to a display.
// Optional sticky error flag oErr is enabled by defining OUFBUF_CTRL_ERR_EN.
module oufbuf_ctrl #(
  parameter int IMG_W = 480,
  parameter int IMG_H = 272,
  parameter int DEPTH = IMG_W * IMG_H
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnClk,
  input  logic        iFrmStart,
  input  logic        iPixValid,
  input  logic [15:0] iPixData,
  output logic        oPixReady,
  output logic        oWrEn,
  output logic [16:0] oWrAddr,
  output logic [15:0] oWrData,
  input  logic        iScanReq,
  output logic [16:0] oRdAddr,
  input  logic [15:0] iRdData,
  output logic        oDispValid,
  output logic [15:0] oDispData,
  output logic        oDispLast,
  output logic        oFrmDone,
  output logic        oBusy
`ifdef OUFBUF_CTRL_ERR_EN
  ,
  output logic        oErr
`endif
);

  localparam int AW = 17;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    FULL,
    SCAN
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [AW-1:0]   rd_cnt_q, rd_cnt_d;
  logic            pend_q, pend_d;
  logic            done_q, done_d;
  logic            dv_q, dv_d;
  logic            dl_q, dl_d;
  logic            in_fill;

  assign in_fill = (state_q == FILL);

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    pend_d   = pend_q;
    done_d   = 1'b0;
    dv_d     = 1'b0;
    dl_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iFrmStart) begin
          state_d  = FILL;
          wr_cnt_d = '0;
        end
      end
      FILL: begin
        // a frame start aborts the frame and swallows a coincident write
        if (iFrmStart) begin
          wr_cnt_d = '0;
        end else if (iPixValid) begin
          if (wr_cnt_q == LAST) begin
            state_d  = FULL;
            wr_cnt_d = '0;
            done_d   = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (iScanReq) begin
          state_d  = SCAN;
          rd_cnt_d = '0;
          pend_d   = iFrmStart;
        end else if (iFrmStart) begin
          state_d  = FILL;
          wr_cnt_d = '0;
        end
      end
      SCAN: begin
        dv_d = 1'b1;
        dl_d = (rd_cnt_q == LAST);
        if (rd_cnt_q == LAST) begin
          rd_cnt_d = '0;
          pend_d   = 1'b0;
          if (pend_q || iFrmStart) begin
            state_d  = FILL;
            wr_cnt_d = '0;
          end else begin
            state_d = FULL;
          end
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (iFrmStart) pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      dv_q     <= 1'b0;
      dl_q     <= 1'b0;
    end else if (iEnClk) begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      dv_q     <= dv_d;
      dl_q     <= dl_d;
    end
  end

`ifdef OUFBUF_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (iPixValid && !in_fill) err_d = 1'b1;
    if (iFrmStart && in_fill && (wr_cnt_q != '0)) err_d = 1'b1;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      err_q <= 1'b0;
    end else if (iEnClk) begin
      err_q <= err_d;
    end
  end

  assign oErr = err_q;
`endif

  assign oPixReady  = in_fill;
  assign oWrEn      = iPixValid & in_fill & iEnClk;
  assign oWrAddr    = wr_cnt_q;
  assign oWrData    = iPixData;
  assign oRdAddr    = rd_cnt_q;
  assign oDispValid = dv_q;
  assign oDispData  = iRdData;
  assign oDispLast  = dl_q;
  assign oFrmDone   = done_q;
  assign oBusy      = (state_q != IDLE);

endmodule

// File: doc/oufbuf_ctrl.md
OUFBUF_CTRL -- requirements
Module: oufbuf_ctrl

Interface
- REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  - IMG_W, 480, frame width in pixels.
  - IMG_H, 272, frame height in lines.
  - DEPTH, IMG_W*IMG_H (130560), buffer words per frame; address width is fixed at 17.
- REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  - iClk, in, 1, single clock.
  - iRst, in, 1, synchronous active-high reset.
  - iEnClk, in, 1, clock enable shared with the buffer.
  - iFrmStart, in, 1, pulse that begins a new CNN output frame.
  - iPixValid, in, 1, CNN pixel valid.
  - iPixData, in, 16, RGB565 pixel.
  - oPixReady, out, 1, controller accepts a pixel.
  - oWrEn, out, 1, buffer write enable.
  - oWrAddr, out, 17, buffer write address.
  - oWrData, out, 16, buffer write data.
  - iScanReq, in, 1, display requests a frame readout.
  - oRdAddr, out, 17, buffer read address.
  - iRdData, in, 16, buffer read data.
  - oDispValid, out, 1, display pixel valid.
  - oDispData, out, 16, display pixel.
  - oDispLast, out, 1, last pixel of the scan.
  - oFrmDone, out, 1, one-cycle pulse when a frame is fully written.
  - oBusy, out, 1, state is not IDLE.

Function
- REQ-003 The FSM SHALL have states IDLE, FILL, FULL and SCAN; all registers SHALL update only on cycles with iEnClk=1, except reset.
- REQ-004 IDLE SHALL go to FILL on iFrmStart, with the write counter cleared to 0.
- REQ-005 In FILL, oPixReady SHALL be 1; in all other states it SHALL be 0.
- REQ-006 oWrEn SHALL equal iPixValid & oPixReady & iEnClk combinationally, with oWrAddr = write counter and oWrData = iPixData (zero latency).
- REQ-007 The write counter SHALL increment by 1 on each write.
- REQ-008 A write at address DEPTH-1 SHALL move the FSM to FULL, clear the write counter to 0, and pulse oFrmDone high for exactly the next enabled cycle.
- REQ-009 iFrmStart during FILL SHALL abort the frame: the write counter restarts at 0 and the FSM stays in FILL; iFrmStart takes priority over a simultaneous write, and that write is not counted.
- REQ-010 FULL SHALL go to SCAN on iScanReq, with the read counter at 0; FULL SHALL go to FILL on iFrmStart.
- REQ-011 If iScanReq and iFrmStart are asserted together in FULL, scan SHALL win and the frame start SHALL be latched as pending.
- REQ-012 In SCAN, oRdAddr SHALL equal the read counter, which increments once per enabled cycle from 0 to DEPTH-1.
- REQ-013 After the read of DEPTH-1, the FSM SHALL return to FULL, or to FILL if a frame start is pending; the pending flag SHALL then clear.
- REQ-014 iFrmStart during SCAN SHALL set pending and SHALL NOT disturb the scan; iScanReq outside FULL SHALL be ignored.
- REQ-015 Display data SHALL have 1-enabled-cycle read latency:
  - oDispValid is registered: 1 in the enabled cycle after each SCAN read cycle.
  - oDispData = iRdData combinationally.
  - oDispLast is registered, high with the oDispValid that carries address DEPTH-1.
- REQ-016 When iEnClk=0, all outputs SHALL hold, except oWrEn, which SHALL be 0.
- REQ-017 A frame SHALL be rescannable any number of times from FULL without rewriting.

Reset
- REQ-018 iRst=1 at a clock edge SHALL, regardless of iEnClk:
  - set the FSM to IDLE;
  - clear both counters and the pending flag;
  - drive oRdAddr=0, oDispValid=0, oDispLast=0, oFrmDone=0, oBusy=0, oPixReady=0.
- REQ-019 Reset mid-FILL or mid-SCAN SHALL abandon the operation with no further oWrEn or oDispValid.

Configuration
- REQ-020 Macro OUFBUF_CTRL_ERR_EN, when defined, SHALL add output oErr (1 bit).
  - oErr is sticky, cleared only by reset.
  - It is set on iPixValid=1 while not in FILL, or on iFrmStart during FILL with the write counter nonzero (aborted frame).
- REQ-021 Without OUFBUF_CTRL_ERR_EN, oErr SHALL be absent and behaviour SHALL otherwise be identical.

Verification
- REQ-022 IMG_W=4, IMG_H=2, iEnClk=1: iFrmStart, then 8 continuous valid pixels 0x0001..0x0008 -> oWrAddr 0..7, oFrmDone one cycle after the 8th write, state FULL.
- REQ-023 From FULL, pulse iScanReq with an RGB565 model buffer -> oRdAddr 0..7 on consecutive cycles; oDispValid one cycle later with data 0x0001..0x0008; oDispLast on 0x0008; return to FULL.
- REQ-024 During a scan at read address 3, pulse iFrmStart -> the scan completes all 8 pixels, then the FSM enters FILL with write counter 0.
- REQ-025 Write 5 pixels, then iFrmStart -> the next pixel is written at address 0; with OUFBUF_CTRL_ERR_EN, oErr=1.
- REQ-026 Toggle iEnClk 1/0 every cycle during FILL and SCAN -> addresses advance only on enabled cycles, oWrEn=0 when disabled, and the data sequence is unchanged.
- REQ-027 Assert iRst at read address 5 of a scan -> next cycle IDLE, oDispValid=0, oRdAddr=0, oBusy=0.
